// File: rtl/pl_ps_mailbox_mem.sv
// Shared 256x32 mailbox between the PS register port and the PL processor
// command port. It also holds the PS control/status word (ready flag and a
// sticky done flag) and produces a one-cycle interrupt on the rising edge of done_pl.
module pl_ps_mailbox_mem #(
    parameter int         DEPTH     = 256,
    parameter logic [7:0] CTRL_ADDR = 8'd252,
    parameter logic [2:0] CMD_WRITE = 3'd2,
    parameter logic [2:0] CMD_READ  = 3'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps_we,
    input  logic        ps_re,
    input  logic [7:0]  ps_addr,
    input  logic [31:0] ps_wdata,
    output logic [31:0] ps_rdata,
    output logic        ps_rvalid,
    output logic        ps_collision,
    output logic        done_irq,
    input  logic [2:0]  cmd,
    input  logic [7:0]  address_pl,
    input  logic [31:0] data_pl,
    input  logic        done_pl,
    output logic [31:0] data_in,
    output logic        ready
);

    logic [31:0] mem [0:DEPTH-1];

    logic [31:0] ps_rdata_reg;
    logic        ps_rvalid_reg;
    logic        ps_collision_reg;
    logic        done_irq_reg;
    logic [31:0] data_in_reg;
    logic        ready_reg;
    logic        done_sticky_reg;
    logic        done_pl_q_reg;

    logic pl_wr;
    logic pl_rd;
    logic ps_ctrl_wr;
    logic collision;
    logic ps_ram_wr;
    logic done_rise;

    // Decode both ports' requests and resolve write priority. On a same-address
    // clash, the PL write wins and the PS write is dropped.
    always_comb begin
        pl_wr      = (cmd == CMD_WRITE);
        pl_rd      = (cmd == CMD_READ);
        ps_ctrl_wr = ps_we && (ps_addr == CTRL_ADDR);
        collision  = ps_we && pl_wr && (ps_addr == address_pl) && (ps_addr != CTRL_ADDR);
        ps_ram_wr  = ps_we && (ps_addr != CTRL_ADDR) && !collision;
        done_rise  = done_pl && !done_pl_q_reg;
    end

    // RAM write port. There is no reset, so the contents survive reset.
    // Writes are suppressed while rst is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (ps_ram_wr) begin
                mem[ps_addr] <= ps_wdata;
            end
            if (pl_wr) begin
                mem[address_pl] <= data_pl;
            end
        end
    end

    // Registered reads, control/status state and pulse outputs. Reads see the
    // pre-write contents of the RAM, so every port behaves read-first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ps_rdata_reg     <= '0;
            ps_rvalid_reg    <= 1'b0;
            ps_collision_reg <= 1'b0;
            done_irq_reg     <= 1'b0;
            data_in_reg      <= '0;
            ready_reg        <= 1'b0;
            done_sticky_reg  <= 1'b0;
            done_pl_q_reg    <= 1'b0;
        end else begin
            ps_rvalid_reg    <= ps_re;
            ps_collision_reg <= collision;
            done_irq_reg     <= done_rise;
            done_pl_q_reg    <= done_pl;
            if (ps_re) begin
                if (ps_addr == CTRL_ADDR) begin
                    ps_rdata_reg <= {30'b0, done_sticky_reg, ready_reg};
                end else begin
                    ps_rdata_reg <= mem[ps_addr];
                end
            end
            if (pl_rd) begin
                data_in_reg <= mem[address_pl];
            end
            if (ps_ctrl_wr) begin
                ready_reg <= ps_wdata[0];
            end
            // A new done edge takes precedence over a same-cycle clear.
            if (done_rise) begin
                done_sticky_reg <= 1'b1;
            end else if (ps_ctrl_wr && ps_wdata[1]) begin
                done_sticky_reg <= 1'b0;
            end
        end
    end

    assign ps_rdata     = ps_rdata_reg;
    assign ps_rvalid    = ps_rvalid_reg;
    assign ps_collision = ps_collision_reg;
    assign done_irq     = done_irq_reg;
    assign data_in      = data_in_reg;
    assign ready        = ready_reg;

endmodule

// File: tb/tb_pl_ps_mailbox_mem.sv
// Directed bench for pl_ps_mailbox_mem. A transaction-level model of the
// mailbox predicts every output each cycle. Literal expectations pin the
// model to hand-computed values.
module tb_pl_ps_mailbox_mem;

    localparam logic [7:0] CTRL = 8'd252;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps_we, ps_re;
    logic [7:0]  ps_addr;
    logic [31:0] ps_wdata;
    logic [31:0] ps_rdata;
    logic        ps_rvalid, ps_collision, done_irq;
    logic [2:0]  cmd;
    logic [7:0]  address_pl;
    logic [31:0] data_pl;
    logic        done_pl;
    logic [31:0] data_in;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    pl_ps_mailbox_mem dut (
        .clk(clk), .rst(rst),
        .ps_we(ps_we), .ps_re(ps_re), .ps_addr(ps_addr), .ps_wdata(ps_wdata),
        .ps_rdata(ps_rdata), .ps_rvalid(ps_rvalid), .ps_collision(ps_collision),
        .done_irq(done_irq), .cmd(cmd), .address_pl(address_pl), .data_pl(data_pl),
        .done_pl(done_pl), .data_in(data_in), .ready(ready)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem   [256];
    bit          m_known [256];
    bit          m_ready, m_sticky, m_prev_done;
    logic [31:0] e_rdata, e_din;
    bit          e_rdata_known, e_din_known;
    bit          e_rvalid, e_coll, e_irq;
    bit          model_en = 1'b0;

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            model_en      = 1'b1;
            e_rdata       = 32'h0;  e_rdata_known = 1'b1;
            e_din         = 32'h0;  e_din_known   = 1'b1;
            e_rvalid      = 1'b0;   e_coll = 1'b0; e_irq = 1'b0;
            m_ready       = 1'b0;   m_sticky = 1'b0; m_prev_done = 1'b0;
        end else if (model_en) begin
            bit rise, coll;
            // reads observe state from before this cycle's writes
            e_rvalid = ps_re;
            if (ps_re) begin
                if (ps_addr == CTRL) begin
                    e_rdata = 32'(m_sticky) * 2 + 32'(m_ready);
                    e_rdata_known = 1'b1;
                end else begin
                    e_rdata = m_mem[ps_addr];
                    e_rdata_known = m_known[ps_addr];
                end
            end
            if (cmd == 3'd3) begin
                e_din = m_mem[address_pl];
                e_din_known = m_known[address_pl];
            end
            rise = done_pl && !m_prev_done;
            m_prev_done = done_pl;
            e_irq = rise;
            if (ps_we && ps_addr == CTRL) begin
                m_ready = ps_wdata[0];
                if (ps_wdata[1]) m_sticky = 1'b0;
            end
            if (rise) m_sticky = 1'b1;
            coll = ps_we && cmd == 3'd2 && ps_addr == address_pl && ps_addr != CTRL;
            e_coll = coll;
            if (ps_we && ps_addr != CTRL) begin
                m_mem[ps_addr] = ps_wdata;
                m_known[ps_addr] = 1'b1;
            end
            if (cmd == 3'd2) begin  // applied last: the PL write wins
                m_mem[address_pl] = data_pl;
                m_known[address_pl] = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: all outputs against the model, every cycle after reset
    always @(negedge clk) begin
        if (model_en) begin
            chk("m_rvalid", 32'(ps_rvalid), 32'(e_rvalid));
            chk("m_coll", 32'(ps_collision), 32'(e_coll));
            chk("m_irq", 32'(done_irq), 32'(e_irq));
            chk("m_ready", 32'(ready), 32'(m_ready));
            if (e_rdata_known) chk("m_rdata", ps_rdata, e_rdata);
            if (e_din_known)   chk("m_din", data_in, e_din);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        ps_we = 0; ps_re = 0; ps_addr = 0; ps_wdata = 0;
        cmd = 3'd0; address_pl = 0; data_pl = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic ps_write(input logic [7:0] a, input logic [31:0] d);
        ps_we = 1; ps_addr = a; ps_wdata = d;
        $display("txn ps_write addr=%0d data=%h", a, d);
        cyc();
        idle();
    endtask

    task automatic ps_read(input logic [7:0] a, input logic [31:0] exp, input string name);
        ps_re = 1; ps_addr = a;
        cyc();
        idle();
        $display("txn ps_read addr=%0d data=%h", a, ps_rdata);
        chk(name, ps_rdata, exp);
        chk({name, "_rvalid"}, 32'(ps_rvalid), 32'd1);
    endtask

    task automatic pl_read(input logic [7:0] a, input logic [31:0] exp, input string name);
        cmd = 3'd3; address_pl = a;
        cyc();
        idle();
        $display("txn pl_read addr=%0d data=%h", a, data_in);
        chk(name, data_in, exp);
    endtask

    initial begin
        int irq_cnt;
        idle();
        done_pl = 0;
        rst = 0;
        cyc(); cyc();
        rst = 1;
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_din", data_in, 32'd0);

        // reset blocks writes and leaves RAM intact
        ps_write(8'd10, 32'h55);
        rst = 0; ps_we = 1; ps_addr = 8'd10; ps_wdata = 32'hAA;
        $display("txn reset with ps_write addr=10 data=000000aa");
        cyc(); cyc();
        chk("rst_rdata", ps_rdata, 32'd0);
        chk("rst_rvalid", 32'(ps_rvalid), 32'd0);
        chk("rst_irq", 32'(done_irq), 32'd0);
        chk("rst_coll", 32'(ps_collision), 32'd0);
        rst = 1; idle();
        ps_read(CTRL, 32'h0, "status_after_reset");
        cyc();
        chk("rvalid_one_cycle", 32'(ps_rvalid), 32'd0);
        ps_read(8'd10, 32'h55, "mem10_retained");

        // PS load, start, PL read
        ps_write(8'd255, 32'h76543210);
        ps_write(8'd254, 32'h00000005);
        ps_write(8'd253, 32'h00000001);
        ps_write(CTRL, 32'h1);
        chk("ready_set", 32'(ready), 32'd1);
        pl_read(8'd255, 32'h76543210, "pl_read_255");
        cmd = 3'd4; cyc(); cyc(); idle();
        chk("din_hold", data_in, 32'h76543210);

        // PL write then PS read
        cmd = 3'd2; address_pl = 8'd1; data_pl = 32'h0B0A0908;
        $display("txn pl_write addr=1 data=0b0a0908");
        cyc(); idle();
        ps_read(8'd1, 32'h0B0A0908, "ps_read_1");

        // collision on the same address
        ps_we = 1; ps_addr = 8'd5; ps_wdata = 32'h11111111;
        cmd = 3'd2; address_pl = 8'd5; data_pl = 32'h22222222;
        $display("txn collide ps/pl addr=5");
        cyc(); idle();
        chk("coll_pulse", 32'(ps_collision), 32'd1);
        ps_read(8'd5, 32'h22222222, "pl_wins");

        // different addresses: both land
        ps_we = 1; ps_addr = 8'd5; ps_wdata = 32'h33333333;
        cmd = 3'd2; address_pl = 8'd6; data_pl = 32'h44444444;
        $display("txn dual write ps addr=5 pl addr=6");
        cyc(); idle();
        chk("no_coll", 32'(ps_collision), 32'd0);
        ps_read(8'd5, 32'h33333333, "dual_5");
        ps_read(8'd6, 32'h44444444, "dual_6");

        // read-first between PS write and PL read
        ps_write(8'd7, 32'h1);
        ps_we = 1; ps_addr = 8'd7; ps_wdata = 32'h2;
        cmd = 3'd3; address_pl = 8'd7;
        $display("txn ps_write addr=7 with pl_read addr=7");
        cyc(); idle();
        chk("read_first_old", data_in, 32'h1);
        pl_read(8'd7, 32'h2, "read_first_new");

        // done edge, sticky status, clear
        irq_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            done_pl = 1; cyc();
            if (done_irq) irq_cnt++;
        end
        done_pl = 0; cyc();
        if (done_irq) irq_cnt++;
        $display("txn done_pl high 5 cycles irq_count=%0d", irq_cnt);
        chk("irq_once", 32'(irq_cnt), 32'd1);
        ps_read(CTRL, 32'h3, "status_done");
        ps_write(CTRL, 32'h2);
        ps_read(CTRL, 32'h0, "status_cleared");

        // set and clear in the same cycle: set wins
        done_pl = 1; ps_we = 1; ps_addr = CTRL; ps_wdata = 32'h2;
        $display("txn done edge with ctrl clear");
        cyc(); idle(); done_pl = 0;
        chk("set_irq", 32'(done_irq), 32'd1);
        ps_read(CTRL, 32'h2, "set_wins");
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
